// File: rtl/gf180mcu_oai_n1_pipe.sv
// Pipelined per-lane OAI (ZN = ~(|A_group & B)), one cycle latency, 2-entry skid so IN_READY is a pure flop.
// Optional macro OAI_PIPE_FILTER_EN adds per-lane toggle filtering of ZN before it is presented.
module gf180mcu_oai_n1_pipe #(
   parameter int CHANNELS = 4,
   parameter int N_IN     = 3,
   parameter int FILT_CNT = 2
) (
   input  logic                       CLK,
   input  logic                       RN,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [CHANNELS*N_IN-1:0]   A,
   input  logic [CHANNELS-1:0]        B,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [CHANNELS-1:0]        ZN
);

   if (CHANNELS < 1 || N_IN < 1 || FILT_CNT < 1 || FILT_CNT > 15) begin : g_bad_param
      $error("gf180mcu_oai_n1_pipe: parameter out of range");
   end

   logic                rdy_q, rdy_d;
   logic                out_vld_q, out_vld_d;
   logic                skid_vld_q, skid_vld_d;
   logic [CHANNELS-1:0] skid_q, skid_d;
   logic [CHANNELS-1:0] zn_q, zn_d;
   logic [CHANNELS-1:0] res;
   logic [CHANNELS-1:0] entry;
   logic                acc, dlv, load;

   always_comb begin
      res = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         res[c] = ~((|A[c*N_IN +: N_IN]) & B[c]);
      end
   end

   // Skid stores the evaluated result; it always drains before a new beat can be taken.
   always_comb begin
      acc        = IN_VALID & rdy_q;
      dlv        = out_vld_q & OUT_READY;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
      load       = 1'b0;
      entry      = res;
      if (skid_vld_q) begin
         entry = skid_q;
         if (dlv) begin
            load       = 1'b1;
            skid_vld_d = 1'b0;
         end
      end else if (!out_vld_q || dlv) begin
         load      = acc;
         out_vld_d = acc;
      end else if (acc) begin
         skid_d     = res;
         skid_vld_d = 1'b1;
      end
      rdy_d = ~skid_vld_d;
   end

`ifdef OAI_PIPE_FILTER_EN
   localparam logic [3:0] FILT_W = 4'(FILT_CNT);

   logic [CHANNELS-1:0][3:0] cnt_q, cnt_d;

   // zn_q doubles as the last-presented value each lane compares against.
   always_comb begin
      zn_d  = zn_q;
      cnt_d = cnt_q;
      if (load) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (entry[c] == zn_q[c]) begin
               cnt_d[c] = 4'd0;
            end else if (cnt_q[c] + 4'd1 == FILT_W) begin
               zn_d[c]  = entry[c];
               cnt_d[c] = 4'd0;
            end else begin
               cnt_d[c] = cnt_q[c] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      zn_d = load ? entry : zn_q;
   end
`endif

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         rdy_q      <= 1'b0;
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_q     <= '0;
         zn_q       <= '1;
      end else begin
         rdy_q      <= rdy_d;
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         skid_q     <= skid_d;
         zn_q       <= zn_d;
      end
   end

   assign IN_READY  = rdy_q;
   assign OUT_VALID = out_vld_q;
   assign ZN        = zn_q;

endmodule
